// File: rtl/rsc2_dec_buffer_ctrl_if.sv
// Handshake bundle between the rsc2 decoder input buffer controller,
// the input source (bank writer) and the decoder engine (bank reader).
interface rsc2_dec_buffer_ctrl_if #(
  parameter int pBNUM = 2
);
  localparam int cBW = (pBNUM > 1) ? $clog2(pBNUM) : 1;

  logic           isop;
  logic           ival;
  logic [3:0]     icode;
  logic [5:0]     iptype;
  logic           iwfull;
  logic           idone;
  logic [cBW-1:0] owbank;
  logic           ofulla;
  logic           oemptya;
  logic           ostart;
  logic [cBW-1:0] ordbank;
  logic [3:0]     ocode;
  logic [5:0]     optype;
  logic           owerr;

  // Source/engine side: drives the requests, observes the bank schedule.
  modport master (
    output isop, ival, icode, iptype, iwfull, idone,
    input  owbank, ofulla, oemptya, ostart, ordbank, ocode, optype, owerr
  );

  // Controller side.
  modport slave (
    input  isop, ival, icode, iptype, iwfull, idone,
    output owbank, ofulla, oemptya, ostart, ordbank, ocode, optype, owerr
  );
endinterface

// File: rtl/rsc2_dec_buffer_ctrl.sv
// Bank scheduler for the rsc2 decoder input buffer: hands filled banks from
// the source to the decoder engine in order, with the code/ptype captured at
// each bank's start of packet, and reports full/empty/overflow status.
module rsc2_dec_buffer_ctrl #(
  parameter int pBNUM = 2
) (
  input  logic                 iclk,
  input  logic                 ireset,
  input  logic                 iclkena,
  rsc2_dec_buffer_ctrl_if.slave bus
);

  localparam int cBW = (pBNUM > 1) ? $clog2(pBNUM) : 1;
  localparam int cUW = $clog2(pBNUM + 1);

  typedef enum logic {
    RIDLE,
    RDEC
  } rstate_t;

  rstate_t        state_q;
  logic [cBW-1:0] wptr_q, wptr_d;
  logic [cBW-1:0] rptr_q, rptr_d;
  logic [cUW-1:0] used_q, used_d;
  logic           wAcc;
  logic           rAcc;

  logic [3:0]     code_q  [pBNUM];
  logic [5:0]     ptype_q [pBNUM];

  logic           ostart_q;
  logic [cBW-1:0] ordbank_q;
  logic [3:0]     ocode_q;
  logic [5:0]     optype_q;
  logic           ofulla_q;
  logic           oemptya_q;
  logic           owerr_q;

  // Accepted write/release events and the resulting pointer and occupancy updates.
  always_comb begin
    wAcc   = bus.iwfull && (used_q != cUW'(pBNUM));
    rAcc   = bus.idone && (state_q == RDEC);
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    used_d = used_q;
    if (wAcc) begin
      wptr_d = (wptr_q == cBW'(pBNUM - 1)) ? '0 : wptr_q + cBW'(1);
    end
    if (rAcc) begin
      rptr_d = (rptr_q == cBW'(pBNUM - 1)) ? '0 : rptr_q + cBW'(1);
    end
    if (wAcc && !rAcc) begin
      used_d = used_q + cUW'(1);
    end else if (!wAcc && rAcc) begin
      used_d = used_q - cUW'(1);
    end
  end

  // Per-bank code/ptype capture at start of packet; the last isop before iwfull wins.
  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      for (int i = 0; i < pBNUM; i++) begin
        code_q[i]  <= '0;
        ptype_q[i] <= '0;
      end
    end else if (iclkena) begin
      if (bus.isop && bus.ival) begin
        code_q[wptr_q]  <= bus.icode;
        ptype_q[wptr_q] <= bus.iptype;
      end
    end
  end

  // Pointers, occupancy, status flags and the reader FSM with its registered outputs.
  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      state_q   <= RIDLE;
      wptr_q    <= '0;
      rptr_q    <= '0;
      used_q    <= '0;
      ostart_q  <= 1'b0;
      ordbank_q <= '0;
      ocode_q   <= '0;
      optype_q  <= '0;
      ofulla_q  <= 1'b0;
      oemptya_q <= 1'b1;
      owerr_q   <= 1'b0;
    end else if (iclkena) begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      used_q    <= used_d;
      ofulla_q  <= (used_d == cUW'(pBNUM));
      oemptya_q <= (used_d == '0);
      owerr_q   <= bus.iwfull && !wAcc;
      ostart_q  <= 1'b0;
      case (state_q)
        RIDLE: begin
          if (used_q != '0) begin
            ostart_q  <= 1'b1;
            ordbank_q <= rptr_q;
            ocode_q   <= code_q[rptr_q];
            optype_q  <= ptype_q[rptr_q];
            state_q   <= RDEC;
          end
        end
        RDEC: begin
          if (bus.idone) begin
            state_q <= RIDLE;
          end
        end
        default: state_q <= RIDLE;
      endcase
    end
  end

  assign bus.owbank  = wptr_q;
  assign bus.ofulla  = ofulla_q;
  assign bus.oemptya = oemptya_q;
  assign bus.ostart  = ostart_q;
  assign bus.ordbank = ordbank_q;
  assign bus.ocode   = ocode_q;
  assign bus.optype  = optype_q;
  assign bus.owerr   = owerr_q;

endmodule

// File: tb/tb_rsc2_dec_buffer_ctrl.sv
// Testbench for rsc2_dec_buffer_ctrl: directed scenarios with literal
// expectations plus randomized traffic against a queue-based bank model.
module tb_rsc2_dec_buffer_ctrl;

  localparam int N = 2;

  logic iclk;
  logic ireset;
  logic iclkena;

  rsc2_dec_buffer_ctrl_if #(.pBNUM(N)) bus ();

  rsc2_dec_buffer_ctrl #(.pBNUM(N)) dut (
    .iclk    (iclk),
    .ireset  (ireset),
    .iclkena (iclkena),
    .bus     (bus)
  );

  int nChecks = 0;
  int nPass   = 0;
  bit cmpOn   = 0;

  // Model state: banks waiting for the engine, plus the one being decoded.
  int         pendQ[$];
  bit         busy;
  int         mWptr;
  logic [3:0] mCode  [N];
  logic [5:0] mPtype [N];
  logic       eStart, eErr, eFull, eEmpty;
  int         eOrd;
  logic [3:0] eCode;
  logic [5:0] ePtype;

  initial begin
    iclk = 1'b0;
    forever #5 iclk = ~iclk;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual == expected) begin
      nPass++;
    end else begin
      $display("[TB] FAIL %s: got %0d, want %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    pendQ.delete();
    busy   = 0;
    mWptr  = 0;
    for (int i = 0; i < N; i++) begin
      mCode[i]  = '0;
      mPtype[i] = '0;
    end
    eStart = 0; eErr = 0; eFull = 0; eEmpty = 1;
    eOrd = 0; eCode = '0; ePtype = '0;
  endtask

  task automatic modelStep();
    int  occ;
    bit  acc;
    int  b;
    occ = pendQ.size() + int'(busy);
    acc = bus.iwfull && (occ < N);
    eErr   = bus.iwfull && !acc;
    eStart = 0;
    if (busy) begin
      if (bus.idone) busy = 0;
    end else if (pendQ.size() > 0) begin
      b      = pendQ.pop_front();
      eStart = 1;
      eOrd   = b;
      eCode  = mCode[b];
      ePtype = mPtype[b];
      busy   = 1;
    end
    if (bus.isop && bus.ival) begin
      mCode[mWptr]  = bus.icode;
      mPtype[mWptr] = bus.iptype;
    end
    if (acc) begin
      pendQ.push_back(mWptr);
      mWptr = (mWptr + 1) % N;
    end
    occ    = pendQ.size() + int'(busy);
    eFull  = (occ == N);
    eEmpty = (occ == 0);
  endtask

  // Reference model advances on every enabled clock edge and on reset.
  initial begin
    modelReset();
    forever begin
      @(posedge iclk or negedge ireset);
      if (!ireset) modelReset();
      else if (iclkena) modelStep();
    end
  end

  // Compare process: outputs checked against the model mid-cycle.
  initial begin
    forever begin
      @(negedge iclk);
      if (cmpOn) begin
        checkOutput("cmp_owbank",  bus.owbank,  mWptr);
        checkOutput("cmp_ofulla",  bus.ofulla,  eFull);
        checkOutput("cmp_oemptya", bus.oemptya, eEmpty);
        checkOutput("cmp_ostart",  bus.ostart,  eStart);
        checkOutput("cmp_ordbank", bus.ordbank, eOrd);
        checkOutput("cmp_ocode",   bus.ocode,   eCode);
        checkOutput("cmp_optype",  bus.optype,  ePtype);
        checkOutput("cmp_owerr",   bus.owerr,   eErr);
      end
    end
  end

  // One cycle of stimulus; returns 1 time unit after the capturing edge with pulses cleared.
  task automatic applyStimulus(input bit sop, input bit val, input int code, input int ptype,
                               input bit wfull, input bit done, input bit ena);
    bus.isop   = sop;
    bus.ival   = val;
    bus.icode  = 4'(code);
    bus.iptype = 6'(ptype);
    bus.iwfull = wfull;
    bus.idone  = done;
    iclkena    = ena;
    @(posedge iclk);
    #1;
    bus.isop   = 1'b0;
    bus.ival   = 1'b0;
    bus.iwfull = 1'b0;
    bus.idone  = 1'b0;
    iclkena    = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic doReset();
    #2;
    ireset = 1'b0;
    @(posedge iclk);
    @(posedge iclk);
    #1;
    ireset = 1'b1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_owbank"},  bus.owbank,  0);
    checkOutput({tag, "_ordbank"}, bus.ordbank, 0);
    checkOutput({tag, "_ocode"},   bus.ocode,   0);
    checkOutput({tag, "_optype"},  bus.optype,  0);
    checkOutput({tag, "_ostart"},  bus.ostart,  0);
    checkOutput({tag, "_owerr"},   bus.owerr,   0);
    checkOutput({tag, "_ofulla"},  bus.ofulla,  0);
    checkOutput({tag, "_oemptya"}, bus.oemptya, 1);
  endtask

  initial begin
    ireset     = 1'b0;
    iclkena    = 1'b1;
    bus.isop   = 1'b0;
    bus.ival   = 1'b0;
    bus.icode  = '0;
    bus.iptype = '0;
    bus.iwfull = 1'b0;
    bus.idone  = 1'b0;
    #12;
    checkResetValues("rst");
    cmpOn = 1;
    @(posedge iclk);
    #1;
    ireset = 1'b1;
    idle(2);

    // Single packet
    applyStimulus(1, 1, 3, 5, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 0, 1);
    checkOutput("sp_owbank",  bus.owbank,  1);
    checkOutput("sp_oemptya", bus.oemptya, 0);
    checkOutput("sp_nostart", bus.ostart,  0);
    idle(1);
    checkOutput("sp_ostart",  bus.ostart,  1);
    checkOutput("sp_ordbank", bus.ordbank, 0);
    checkOutput("sp_ocode",   bus.ocode,   3);
    checkOutput("sp_optype",  bus.optype,  5);
    idle(1);
    checkOutput("sp_pulse1", bus.ostart, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 1);
    checkOutput("sp_empty_again", bus.oemptya, 1);
    idle(2);
    checkOutput("sp_no_restart", bus.ostart, 0);

    // Fill to full, overflow, back-to-back drain
    doReset();
    applyStimulus(1, 1, 1, 10, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 0, 1);
    checkOutput("ff_notfull", bus.ofulla, 0);
    applyStimulus(1, 1, 7, 20, 0, 0, 1);
    checkOutput("ff_start0", bus.ostart, 1);
    checkOutput("ff_code0",  bus.ocode,  1);
    applyStimulus(0, 0, 0, 0, 1, 0, 1);
    checkOutput("ff_full",   bus.ofulla, 1);
    checkOutput("ff_wrap",   bus.owbank, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 1);
    checkOutput("ff_owerr",      bus.owerr,  1);
    checkOutput("ff_owbank_hold", bus.owbank, 0);
    checkOutput("ff_full_hold",  bus.ofulla, 1);
    idle(1);
    checkOutput("ff_owerr_pulse", bus.owerr, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 1);
    checkOutput("dr_notfull", bus.ofulla, 0);
    checkOutput("dr_nostart", bus.ostart, 0);
    idle(1);
    checkOutput("dr_start",   bus.ostart,  1);
    checkOutput("dr_ordbank", bus.ordbank, 1);
    checkOutput("dr_ocode",   bus.ocode,   7);
    checkOutput("dr_optype",  bus.optype,  20);

    // Simultaneous accepted write and release
    applyStimulus(0, 0, 0, 0, 1, 1, 1);
    checkOutput("sim_notempty", bus.oemptya, 0);
    checkOutput("sim_notfull",  bus.ofulla,  0);
    checkOutput("sim_owbank",   bus.owbank,  1);
    idle(1);
    checkOutput("sim_start",   bus.ostart,  1);
    checkOutput("sim_ordbank", bus.ordbank, 0);
    checkOutput("sim_ocode",   bus.ocode,   1);

    // Stray idone in RIDLE, then clock-enable gating of iwfull
    applyStimulus(0, 0, 0, 0, 0, 1, 1);
    idle(1);
    applyStimulus(0, 0, 0, 0, 0, 1, 1);
    checkOutput("stray_empty",  bus.oemptya, 1);
    checkOutput("stray_owbank", bus.owbank,  1);
    checkOutput("stray_ostart", bus.ostart,  0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkOutput("ena_owbank", bus.owbank,  1);
    checkOutput("ena_empty",  bus.oemptya, 1);
    idle(2);
    checkOutput("ena_nostart", bus.ostart, 0);

    // Reset mid-decode with two banks in use
    applyStimulus(0, 0, 0, 0, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 0, 1);
    checkOutput("rmd_start", bus.ostart, 1);
    checkOutput("rmd_full",  bus.ofulla, 1);
    #2;
    ireset = 1'b0;
    #1;
    checkResetValues("rmd");
    @(posedge iclk);
    #1;
    ireset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 1, 1);
    checkOutput("rmd_done_ignored", bus.oemptya, 1);
    idle(1);
    checkOutput("rmd_no_start", bus.ostart, 0);

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(599) == 0) begin
        doReset();
      end else begin
        applyStimulus($urandom_range(99) < 20, $urandom_range(1),
                      int'($urandom_range(15)), int'($urandom_range(63)),
                      $urandom_range(99) < 35, $urandom_range(99) < 30,
                      $urandom_range(99) < 90);
      end
    end

    idle(2);
    cmpOn = 0;
    $display("[TB] %0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
